// File: rtl/ascon_perm_seq.sv
// ascon_perm_seq: iterative Ascon permutation sequencer (p^6/p^8/p^12) around UNROLL chained ascon_p rounds.
module ascon_p (
  input  logic [319:0] i_state,
  input  logic [7:0]   i_cr,
  output logic [319:0] o_state
);
  function automatic logic [63:0] ror(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction
  logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [63:0] w_c0, w_c1, w_c2, w_c3, w_c4;
  assign w_a0 = i_state[319:256] ^ i_state[63:0];
  assign w_a1 = i_state[255:192];
  assign w_a2 = i_state[191:128] ^ {56'd0, i_cr} ^ i_state[255:192];
  assign w_a3 = i_state[127:64];
  assign w_a4 = i_state[63:0] ^ i_state[127:64];
  // chi-like core of the bitsliced 5-bit S-box
  assign w_b0 = w_a0 ^ (~w_a1 & w_a2);
  assign w_b1 = w_a1 ^ (~w_a2 & w_a3);
  assign w_b2 = w_a2 ^ (~w_a3 & w_a4);
  assign w_b3 = w_a3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & w_a1);
  assign w_c0 = w_b0 ^ w_b4;
  assign w_c1 = w_b1 ^ w_b0;
  assign w_c2 = ~w_b2;
  assign w_c3 = w_b3 ^ w_b2;
  assign w_c4 = w_b4;
  assign o_state = {w_c0 ^ ror(w_c0, 19) ^ ror(w_c0, 28),
                    w_c1 ^ ror(w_c1, 61) ^ ror(w_c1, 39),
                    w_c2 ^ ror(w_c2, 1)  ^ ror(w_c2, 6),
                    w_c3 ^ ror(w_c3, 10) ^ ror(w_c3, 17),
                    w_c4 ^ ror(w_c4, 7)  ^ ror(w_c4, 41)};
endmodule

module ascon_perm_seq #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   nrounds_i,
  input  logic [319:0] state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] state_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  fsm_t         r_fsm, w_fsm_nxt;
  logic [319:0] r_st;
  logic [3:0]   r_rnd, w_rnd_nxt, w_n;
  logic [319:0] w_chain [UNROLL+1];
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad
    $error("ascon_perm_seq: UNROLL must be 1 or 2");
  end
  assign w_chain[0] = r_st;
  for (genvar k = 0; k < UNROLL; k++) begin : g_rnd
    logic [3:0] w_i;
    assign w_i = r_rnd + 4'(k);
    ascon_p u_p (.i_state(w_chain[k]), .i_cr({4'hF - w_i, w_i}), .o_state(w_chain[k+1]));
  end
  assign w_n = (nrounds_i == 4'd6 || nrounds_i == 4'd8) ? nrounds_i : 4'd12;
  assign w_rnd_nxt = r_rnd + 4'(UNROLL);
  always_comb begin
    w_fsm_nxt = (r_fsm == IDLE) ? (in_valid_i ? RUN : IDLE) :
                (r_fsm == RUN)  ? ((w_rnd_nxt == 4'd12) ? DONE : RUN) :
                (out_ready_i ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm <= IDLE;
      r_st  <= '0;
      r_rnd <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm == IDLE && in_valid_i) begin
        r_st  <= state_i;
        r_rnd <= 4'd12 - w_n;
      end else if (r_fsm == RUN) begin
        r_st  <= w_chain[UNROLL];
        r_rnd <= w_rnd_nxt;
      end
    end
  end
  assign in_ready_o  = (r_fsm == IDLE);
  assign out_valid_o = (r_fsm == DONE);
  assign busy_o      = (r_fsm == RUN);
  assign state_o     = r_st;
endmodule
